// File: rtl/store_commit_buffer_if.sv
// Store request channel from the post-commit store buffer to the L1 data cache.
// Handshake: a request transfers on a rising edge where dc_valid_out && dc_ready_in; the cache later
// pulses dc_ack_in for one cycle when the write completes, and at most one request is outstanding.
interface store_commit_buffer_if #(
  parameter int ADDR_BITS = 64,
  parameter int WORD_SIZE = 64
);
  logic                 dc_valid_out;
  logic                 dc_ready_in;
  logic [ADDR_BITS-1:0] dc_addr_out;
  logic [WORD_SIZE-1:0] dc_data_out;
  logic                 dc_ack_in;

  modport master (
    output dc_valid_out, dc_addr_out, dc_data_out,
    input  dc_ready_in, dc_ack_in
  );

  modport slave (
    input  dc_valid_out, dc_addr_out, dc_data_out,
    output dc_ready_in, dc_ack_in
  );
endinterface

// File: rtl/store_commit_buffer.sv
// Post-commit store buffer: reads committed store operands, queues {addr, data} in program order and
// drains them one at a time to the L1 cache. Optional store-to-load forwarding: STORE_BUF_FWD_EN.
module store_commit_buffer #(
  parameter int Q_WIDTH   = 4,
  parameter int SB_DEPTH  = 8,
  parameter int ADDR_BITS = 64,
  parameter int WORD_SIZE = 64,
  parameter int REG_BITS  = 5
) (
  input  logic                                 clk_in,
  input  logic                                 rst_N_in,
  input  logic [Q_WIDTH-1:0]                   valid_str_in,
  input  logic [Q_WIDTH-1:0][REG_BITS-1:0]     str_addr_reg_in,
  input  logic [Q_WIDTH-1:0][REG_BITS-1:0]     str_addr_reg_off_in,
  input  logic [Q_WIDTH-1:0][REG_BITS-1:0]     str_val_reg_in,
  output logic                                 stall_commit_out,
  output logic [Q_WIDTH-1:0][2:0][REG_BITS-1:0] rf_rd_addr_out,
  input  logic [Q_WIDTH-1:0][2:0][WORD_SIZE-1:0] rf_rd_data_in,
  store_commit_buffer_if.master                dc,
  output logic                                 empty_out,
  output logic [1:0]                           drain_state_dbg
`ifdef STORE_BUF_FWD_EN
  ,
  input  logic [ADDR_BITS-1:0]                 ld_addr_in,
  output logic                                 fwd_hit_out,
  output logic [WORD_SIZE-1:0]                 fwd_data_out,
  output logic                                 fwd_pending_out
`endif
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    DRAIN_IDLE     = 2'd0,
    DRAIN_REQ      = 2'd1,
    DRAIN_WAIT_ACK = 2'd2
  } drain_state_t;

  drain_state_t         drain_state;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;
  logic [Q_WIDTH-1:0]   r_valid;
  logic [CNT_W-1:0]     push_cnt;
  logic [PTR_W-1:0]     lane_slot [Q_WIDTH];
  logic                 pop;
  logic [PTR_W-1:0]     head_next;

  logic [ADDR_BITS-1:0] sb_addr [SB_DEPTH];
  logic [WORD_SIZE-1:0] sb_data [SB_DEPTH];

  // Read stage: invalid lanes present register 0 so the register file sees a quiet port.
  always_comb begin
    for (int i = 0; i < Q_WIDTH; i++) begin
      rf_rd_addr_out[i][0] = valid_str_in[i] ? str_addr_reg_in[i]     : '0;
      rf_rd_addr_out[i][1] = valid_str_in[i] ? str_addr_reg_off_in[i] : '0;
      rf_rd_addr_out[i][2] = valid_str_in[i] ? str_val_reg_in[i]      : '0;
    end
  end

  // Valid lanes are compacted to consecutive slots from tail, keeping lane (program) order.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < Q_WIDTH; i++) begin
      lane_slot[i] = tail + push_cnt[PTR_W-1:0];
      if (r_valid[i]) push_cnt = push_cnt + CNT_W'(1);
    end
  end

  // Stores already in the read stage are reserved so they always find a free slot.
  always_comb begin
    stall_commit_out = (int'(SB_DEPTH) - int'(count) - int'(push_cnt)) < Q_WIDTH;
  end

  always_comb begin
    pop       = (drain_state == DRAIN_WAIT_ACK) && dc.dc_ack_in;
    head_next = head + PTR_W'(1);
    empty_out = (count == '0) && (r_valid == '0);
    drain_state_dbg = drain_state;
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      r_valid <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      r_valid <= valid_str_in & {Q_WIDTH{~stall_commit_out}};
      tail    <= tail + push_cnt[PTR_W-1:0];
      head    <= head + PTR_W'(pop);
      count   <= count + push_cnt - CNT_W'(pop);
    end
  end

  // Entry storage carries no reset; count/head/tail define which slots are live.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < Q_WIDTH; i++) begin
      if (r_valid[i]) begin
        sb_addr[lane_slot[i]] <= ADDR_BITS'(rf_rd_data_in[i][0]) + ADDR_BITS'(rf_rd_data_in[i][1]);
        sb_data[lane_slot[i]] <= rf_rd_data_in[i][2];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      drain_state     <= DRAIN_IDLE;
      dc.dc_valid_out <= 1'b0;
      dc.dc_addr_out  <= '0;
      dc.dc_data_out  <= '0;
    end else begin
      case (drain_state)
        DRAIN_IDLE: begin
          if (count != '0) begin
            drain_state     <= DRAIN_REQ;
            dc.dc_valid_out <= 1'b1;
            dc.dc_addr_out  <= sb_addr[head];
            dc.dc_data_out  <= sb_data[head];
          end
        end
        DRAIN_REQ: begin
          if (dc.dc_ready_in) begin
            drain_state     <= DRAIN_WAIT_ACK;
            dc.dc_valid_out <= 1'b0;
          end
        end
        DRAIN_WAIT_ACK: begin
          // The head entry stays counted until its ack, so count > 1 means another is ready.
          if (dc.dc_ack_in) begin
            if (count > CNT_W'(1)) begin
              drain_state     <= DRAIN_REQ;
              dc.dc_valid_out <= 1'b1;
              dc.dc_addr_out  <= sb_addr[head_next];
              dc.dc_data_out  <= sb_data[head_next];
            end else begin
              drain_state <= DRAIN_IDLE;
            end
          end
        end
        default: begin
          drain_state     <= DRAIN_IDLE;
          dc.dc_valid_out <= 1'b0;
        end
      endcase
    end
  end

`ifdef STORE_BUF_FWD_EN
  // Scan oldest to youngest so the youngest matching entry wins; the in-flight head is included.
  always_comb begin
    fwd_hit_out     = 1'b0;
    fwd_data_out    = '0;
    fwd_pending_out = |r_valid;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (sb_addr[head + PTR_W'(i)] == ld_addr_in)) begin
        fwd_hit_out  = 1'b1;
        fwd_data_out = sb_data[head + PTR_W'(i)];
      end
    end
  end
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Bench for store_commit_buffer: randomized commits and cache handshakes against a queue-based model;
// define STORE_BUF_FWD_EN to also exercise forwarding.
module tb_store_commit_buffer;
  localparam int QW    = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 64;
  localparam int WS    = 64;
  localparam int RB    = 5;

  typedef logic [QW-1:0][2:0][RB-1:0] regs_t;

  logic                        clk_in = 1'b0;
  logic                        rst_N_in;
  logic [QW-1:0]               valid_str_in;
  logic [QW-1:0][RB-1:0]       str_addr_reg_in;
  logic [QW-1:0][RB-1:0]       str_addr_reg_off_in;
  logic [QW-1:0][RB-1:0]       str_val_reg_in;
  logic                        stall_commit_out;
  logic [QW-1:0][2:0][RB-1:0]  rf_rd_addr_out;
  logic [QW-1:0][2:0][WS-1:0]  rf_rd_data_in;
  logic                        empty_out;
  logic [1:0]                  drain_state_dbg;
`ifdef STORE_BUF_FWD_EN
  logic [AW-1:0]               ld_addr_in;
  logic                        fwd_hit_out;
  logic [WS-1:0]               fwd_data_out;
  logic                        fwd_pending_out;
`endif

  store_commit_buffer_if #(.ADDR_BITS(AW), .WORD_SIZE(WS)) dc_if ();

  store_commit_buffer #(
    .Q_WIDTH(QW), .SB_DEPTH(DEPTH), .ADDR_BITS(AW), .WORD_SIZE(WS), .REG_BITS(RB)
  ) dut (
    .clk_in              (clk_in),
    .rst_N_in            (rst_N_in),
    .valid_str_in        (valid_str_in),
    .str_addr_reg_in     (str_addr_reg_in),
    .str_addr_reg_off_in (str_addr_reg_off_in),
    .str_val_reg_in      (str_val_reg_in),
    .stall_commit_out    (stall_commit_out),
    .rf_rd_addr_out      (rf_rd_addr_out),
    .rf_rd_data_in       (rf_rd_data_in),
    .dc                  (dc_if),
    .empty_out           (empty_out),
    .drain_state_dbg     (drain_state_dbg)
`ifdef STORE_BUF_FWD_EN
    ,
    .ld_addr_in          (ld_addr_in),
    .fwd_hit_out         (fwd_hit_out),
    .fwd_data_out        (fwd_data_out),
    .fwd_pending_out     (fwd_pending_out)
`endif
  );

  // ---------------- clock / register file ----------------
  always #5 clk_in = ~clk_in;

  logic [63:0] rf [32];

  always @(posedge clk_in) begin
    for (int i = 0; i < QW; i++)
      for (int j = 0; j < 3; j++)
        rf_rd_data_in[i][j] <= rf[rf_rd_addr_out[i][j]];
  end

  always @(posedge clk_in) begin
    if (rst_N_in && stall_commit_out && (|valid_str_in))
      $error("protocol: store presented while stall_commit_out is high");
  end

  // ---------------- scoreboard / model ----------------
  logic [AW-1:0] exp_addr_q[$];
  logic [WS-1:0] exp_q[$];
  int          m_count;
  int          m_pend;
  bit          awaiting;
  bit          hold_chk;
  logic [63:0] hold_addr;
  logic [63:0] hold_data;
  int          accepted_total;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_clear();
    exp_addr_q.delete();
    exp_q.delete();
    m_count  = 0;
    m_pend   = 0;
    awaiting = 0;
    hold_chk = 0;
  endtask

  function automatic regs_t rand_regs();
    regs_t r;
    for (int i = 0; i < QW; i++)
      for (int j = 0; j < 3; j++)
        r[i][j] = RB'($urandom_range(0, 31));
    return r;
  endfunction

  // One clock: drive inputs, score any request handshake, advance, then check stall/empty.
  task automatic step(input logic [QW-1:0] vmask, input regs_t regs, input logic ready, input logic ack);
    logic [QW-1:0] acc;
    bit hs;
    bit pop;
    int n_acc;
    acc = stall_commit_out ? '0 : vmask;
    valid_str_in = acc;
    for (int i = 0; i < QW; i++) begin
      str_addr_reg_in[i]     = regs[i][0];
      str_addr_reg_off_in[i] = regs[i][1];
      str_val_reg_in[i]      = regs[i][2];
    end
    dc_if.dc_ready_in = ready;
    dc_if.dc_ack_in   = ack;
    if (hold_chk) begin
      check("req_hold_valid", dc_if.dc_valid_out, 1'b1);
      check("req_hold_addr", dc_if.dc_addr_out, hold_addr);
      check("req_hold_data", dc_if.dc_data_out, hold_data);
    end
    hs = dc_if.dc_valid_out && ready;
    if (hs) begin
      if (exp_addr_q.size() == 0) begin
        check("req_unexpected", dc_if.dc_valid_out, 1'b0);
      end else begin
        check("req_addr", dc_if.dc_addr_out, exp_addr_q.pop_front());
        check("req_data", dc_if.dc_data_out, exp_q.pop_front());
      end
    end
    hold_chk  = dc_if.dc_valid_out && !ready;
    hold_addr = dc_if.dc_addr_out;
    hold_data = dc_if.dc_data_out;
    pop = awaiting && ack;
    n_acc = 0;
    for (int i = 0; i < QW; i++) begin
      if (acc[i]) begin
        exp_addr_q.push_back(rf[regs[i][0]] + rf[regs[i][1]]);
        exp_q.push_back(rf[regs[i][2]]);
        n_acc++;
      end
    end
    accepted_total += n_acc;
    tick();
    m_count  = m_count + m_pend - int'(pop);
    m_pend   = n_acc;
    awaiting = (awaiting && !ack) || hs;
    check("stall", stall_commit_out, (DEPTH - m_count - m_pend) < QW);
    check("empty", empty_out, (m_count == 0) && (m_pend == 0));
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && (m_count != 0 || m_pend != 0 || awaiting); k++)
      step('0, '0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("drain_left", exp_q.size(), 0);
    check("drained_empty", empty_out, 1'b1);
  endtask

  task automatic do_reset();
    rst_N_in          = 1'b0;
    valid_str_in      = '0;
    str_addr_reg_in   = '0;
    str_addr_reg_off_in = '0;
    str_val_reg_in    = '0;
    dc_if.dc_ready_in = 1'b0;
    dc_if.dc_ack_in   = 1'b0;
    model_clear();
    repeat (2) @(posedge clk_in);
    #1;
    rst_N_in = 1'b1;
    tick();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_dc_valid"}, dc_if.dc_valid_out, 1'b0);
    check({pfx, "_dc_addr"}, dc_if.dc_addr_out, '0);
    check({pfx, "_dc_data"}, dc_if.dc_data_out, '0);
    check({pfx, "_stall"}, stall_commit_out, 1'b0);
    check({pfx, "_empty"}, empty_out, 1'b1);
`ifdef STORE_BUF_FWD_EN
    check({pfx, "_fwd_hit"}, fwd_hit_out, 1'b0);
    check({pfx, "_fwd_data"}, fwd_data_out, '0);
    check({pfx, "_fwd_pend"}, fwd_pending_out, 1'b0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    regs_t r;
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
    rf[0]  = 64'h0;
    rf[1]  = 64'h1000;
    rf[2]  = 64'h8;
    rf[3]  = 64'hDEAD;
    rf[4]  = 64'h100;
    rf[5]  = 64'h0;
    rf[6]  = 64'h200;
    rf[7]  = 64'hAAAA;
    rf[8]  = 64'hBBBB;
    rf[10] = 64'h40;
    rf[11] = 64'h1;
    rf[12] = 64'h2;
    rf[30] = 64'hFFFF_FFFF_FFFF_FFF8;
    rf[31] = 64'h10;
`ifdef STORE_BUF_FWD_EN
    ld_addr_in = '0;
`endif
    accepted_total = 0;

    // reset values
    rst_N_in = 1'b0;
    #1;
    check_reset_outputs("rst0");
    do_reset();
    check_reset_outputs("rst1");

    // single store latency: commit at cycle 0, request visible at cycle 3
    r = '0;
    r[0][0] = 5'd1; r[0][1] = 5'd2; r[0][2] = 5'd3;
    step(4'b0001, r, 1'b0, 1'b0);
    check("lat_c1_valid", dc_if.dc_valid_out, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    check("lat_c2_valid", dc_if.dc_valid_out, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    check("lat_c3_valid", dc_if.dc_valid_out, 1'b1);
    check("lat_c3_addr", dc_if.dc_addr_out, 64'h1008);
    check("lat_c3_data", dc_if.dc_data_out, 64'hDEAD);
    drain();

    // multi-lane order: lanes 0 and 2 in one cycle
    r = '0;
    r[0][0] = 5'd4; r[0][1] = 5'd5; r[0][2] = 5'd7;
    r[2][0] = 5'd6; r[2][1] = 5'd5; r[2][2] = 5'd8;
    step(4'b0101, r, 1'b0, 1'b0);
    repeat (3) step('0, '0, 1'b0, 1'b0);
    check("order_first_addr", dc_if.dc_addr_out, 64'h100);
    drain();

    // full / backpressure with the cache stalled
    accepted_total = 0;
    for (int k = 0; k < 6; k++) step(4'hF, rand_regs(), 1'b0, 1'b0);
    check("fill_total", accepted_total, DEPTH);
    check("fill_stall", stall_commit_out, 1'b1);
    drain();

    // address wrap plus 3*DEPTH random stores with random ready/ack
    r = '0;
    r[0][0] = 5'd30; r[0][1] = 5'd31; r[0][2] = 5'd3;
    step(4'b0001, r, 1'b0, 1'b0);
    repeat (3) step('0, '0, 1'b0, 1'b0);
    check("wrap_addr", dc_if.dc_addr_out, 64'h8);
    accepted_total = 0;
    for (int k = 0; k < 400 && accepted_total < 3 * DEPTH; k++)
      step(($urandom_range(0, 99) < 60) ? QW'($urandom) : '0, rand_regs(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("random_volume", accepted_total >= 3 * DEPTH, 1'b1);
    drain();

    // reset while waiting for an ack with 5 entries queued
    step(4'hF, rand_regs(), 1'b0, 1'b0);
    step(4'b0001, rand_regs(), 1'b0, 1'b0);
    for (int k = 0; k < 20 && !awaiting; k++) step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    check("rstmid_in_wait", dc_if.dc_valid_out, 1'b0);
    check("rstmid_not_empty", empty_out, 1'b0);
    #2;
    rst_N_in = 1'b0;
    #1;
    check_reset_outputs("rstmid");
    dc_if.dc_ack_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_N_in = 1'b1;
    model_clear();
    step('0, '0, 1'b0, 1'b1);
    repeat (3) step('0, '0, 1'b1, 1'b0);
    check("late_ack_valid", dc_if.dc_valid_out, 1'b0);
    r = '0;
    r[0][0] = 5'd1; r[0][1] = 5'd2; r[0][2] = 5'd3;
    step(4'b0001, r, 1'b0, 1'b0);
    drain();

`ifdef STORE_BUF_FWD_EN
    // forwarding: two stores to 0x40, youngest data wins
    ld_addr_in = 64'h40;
    r = '0;
    r[0][0] = 5'd10; r[0][1] = 5'd5; r[0][2] = 5'd11;
    r[1][0] = 5'd10; r[1][1] = 5'd5; r[1][2] = 5'd12;
    step(4'b0011, r, 1'b0, 1'b0);
    check("fwd_pending", fwd_pending_out, 1'b1);
    step('0, '0, 1'b0, 1'b0);
    check("fwd_hit", fwd_hit_out, 1'b1);
    check("fwd_data", fwd_data_out, 64'h2);
    ld_addr_in = 64'h48;
    #1;
    check("fwd_miss", fwd_hit_out, 1'b0);
    ld_addr_in = 64'h40;
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
